branch_resolve_m: RTL and testbench



---
 rtl/branch_resolve_m.sv | 108 ++++++++++
 tb/tb_branch_resolve_m.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_m.sv
// MEM-stage branch resolution: registers EX branch operands, resolves in M, redirects fetch and flushes D/E.
// Latency: branch in E at cycle n redirects in cycle n+1; stallM holds M, done flag keeps redirect to one cycle.
module branch_resolve_m #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             validE,
    input  logic [2:0]       br_opE,
    input  logic [31:0]      rsE,
    input  logic [31:0]      rtE,
    input  logic [31:0]      pcbranchE,
    input  logic             stallM,
    output logic             pc_srcM,
    output logic [31:0]      pcbranchM,
    output logic             flushD,
    output logic             flushE,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    logic             valid_q, valid_d;
    logic [2:0]       br_op_q, br_op_d;
    logic [31:0]      rs_q, rs_d;
    logic [31:0]      rt_q, rt_d;
    logic [31:0]      pcbranch_q, pcbranch_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

    logic taken;
    logic is_branch;
    logic br_evt;

    always_comb begin
        taken = 1'b0;
        case (br_op_q)
            3'b001:  taken = (rs_q == rt_q);
            3'b010:  taken = (rs_q != rt_q);
            3'b011:  taken = ($signed(rs_q) <= 32'sd0);
            3'b100:  taken = ($signed(rs_q) >  32'sd0);
            3'b101:  taken = ($signed(rs_q) <  32'sd0);
            3'b110:  taken = ($signed(rs_q) >= 32'sd0);
            3'b111:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    assign is_branch = valid_q & (br_op_q != 3'b000);
    // done masks both redirect and counting once the branch in M has resolved under a stall
    assign br_evt    = is_branch & ~done_q & ~clr;
    assign pc_srcM   = valid_q & taken & ~done_q & ~clr;

    assign pcbranchM = pcbranch_q;
    assign flushD    = pc_srcM;
    assign flushE    = pc_srcM;
    assign br_cnt    = br_cnt_q;
    assign taken_cnt = taken_cnt_q;

    always_comb begin
        valid_d     = valid_q;
        br_op_d     = br_op_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        pcbranch_d  = pcbranch_q;
        done_d      = done_q;
        br_cnt_d    = br_cnt_q + {{(CNT_W-1){1'b0}}, br_evt};
        taken_cnt_d = taken_cnt_q + {{(CNT_W-1){1'b0}}, pc_srcM};
        if (stallM) begin
            done_d = done_q | is_branch;
        end else if (pc_srcM) begin
            // the instruction in E is younger than the taken branch
            valid_d = 1'b0;
            br_op_d = 3'b000;
            done_d  = 1'b0;
        end else begin
            valid_d    = validE;
            br_op_d    = br_opE;
            rs_d       = rsE;
            rt_d       = rtE;
            pcbranch_d = pcbranchE;
            done_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            valid_q     <= 1'b0;
            br_op_q     <= 3'b000;
            rs_q        <= 32'd0;
            rt_q        <= 32'd0;
            pcbranch_q  <= 32'd0;
            done_q      <= 1'b0;
            br_cnt_q    <= '0;
            taken_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            br_op_q     <= br_op_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            pcbranch_q  <= pcbranch_d;
            done_q      <= done_d;
            br_cnt_q    <= br_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

endmodule

// File: tb/tb_branch_resolve_m.sv
// Bench for branch_resolve_m: per-cycle model compare on two widths plus directed literal checks.
module tb_branch_resolve_m;

    logic        clk = 1'b0;
    logic        clr;
    logic        validE;
    logic [2:0]  br_opE;
    logic [31:0] rsE, rtE, pcbranchE;
    logic        stallM;

    logic        pc_src_a, flushD_a, flushE_a;
    logic [31:0] pcbranch_a, br_cnt_a, taken_cnt_a;
    logic        pc_src_b, flushD_b, flushE_b;
    logic [31:0] pcbranch_b;
    logic [3:0]  br_cnt_b, taken_cnt_b;

    int errors = 0;
    int checks = 0;

    branch_resolve_m #(.CNT_W(32)) dut_a (
        .clk(clk), .clr(clr), .validE(validE), .br_opE(br_opE), .rsE(rsE), .rtE(rtE),
        .pcbranchE(pcbranchE), .stallM(stallM), .pc_srcM(pc_src_a), .pcbranchM(pcbranch_a),
        .flushD(flushD_a), .flushE(flushE_a), .br_cnt(br_cnt_a), .taken_cnt(taken_cnt_a)
    );

    branch_resolve_m #(.CNT_W(4)) dut_b (
        .clk(clk), .clr(clr), .validE(validE), .br_opE(br_opE), .rsE(rsE), .rtE(rtE),
        .pcbranchE(pcbranchE), .stallM(stallM), .pc_srcM(pc_src_b), .pcbranchM(pcbranch_b),
        .flushD(flushD_b), .flushE(flushE_b), .br_cnt(br_cnt_b), .taken_cnt(taken_cnt_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Model: the branch sitting in M, whether it already fired, and event totals.
    bit          m_live;
    bit [2:0]    m_kind;
    int          m_rs, m_rt;
    bit [31:0]   m_tgt;
    bit          m_fired;
    bit [31:0]   n_resolved, n_taken;

    function automatic bit cond_holds(bit [2:0] kind, int a, int b);
        case (kind)
            3'd1: return a == b;
            3'd2: return a != b;
            3'd3: return a <= 0;
            3'd4: return a > 0;
            3'd5: return a < 0;
            3'd6: return a >= 0;
            3'd7: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        m_live = 0; m_kind = 0; m_rs = 0; m_rt = 0; m_tgt = 0; m_fired = 0;
        n_resolved = 0; n_taken = 0;
    end

    // Inputs change at posedge+2, so at negedge they are exactly what the next edge samples.
    always @(negedge clk) begin
        bit redirect, resolves;
        resolves = m_live && m_kind != 0 && !m_fired && !clr;
        redirect = resolves && cond_holds(m_kind, m_rs, m_rt);
        chk("pc_srcM",   {31'd0, pc_src_a}, {31'd0, redirect});
        chk("flushD",    {31'd0, flushD_a}, {31'd0, redirect});
        chk("flushE",    {31'd0, flushE_a}, {31'd0, redirect});
        chk("pcbranchM", pcbranch_a, m_tgt);
        chk("br_cnt",    br_cnt_a, n_resolved);
        chk("taken_cnt", taken_cnt_a, n_taken);
        chk("pc_srcM_w4", {31'd0, pc_src_b}, {31'd0, redirect});
        chk("br_cnt_w4",    {28'd0, br_cnt_b}, n_resolved % 16);
        chk("taken_cnt_w4", {28'd0, taken_cnt_b}, n_taken % 16);
        if (clr) begin
            m_live = 0; m_kind = 0; m_rs = 0; m_rt = 0; m_tgt = 0; m_fired = 0;
            n_resolved = 0; n_taken = 0;
        end else begin
            if (resolves) n_resolved++;
            if (redirect) n_taken++;
            if (stallM) begin
                if (m_live && m_kind != 0) m_fired = 1;
            end else if (redirect) begin
                m_live = 0; m_kind = 0; m_fired = 0;
            end else begin
                m_live = validE; m_kind = br_opE; m_rs = rsE; m_rt = rtE;
                m_tgt = pcbranchE; m_fired = 0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic put(input bit v, input bit [2:0] op, input bit [31:0] a, input bit [31:0] b,
                       input bit [31:0] tgt);
        validE = v; br_opE = op; rsE = a; rtE = b; pcbranchE = tgt;
    endtask

    initial begin
        clr = 1'b1; stallM = 1'b0;
        put(1, 3'd1, 32'h5, 32'h5, 32'h40);
        step(2);
        chk("rst_pc_src", {31'd0, pc_src_a}, 32'd0);
        chk("rst_br_cnt", br_cnt_a, 32'd0);
        chk("rst_taken_cnt", taken_cnt_a, 32'd0);

        clr = 1'b0;
        step(1);
        chk("beq_pc_src", {31'd0, pc_src_a}, 32'd1);
        chk("beq_target", pcbranch_a, 32'h40);
        chk("beq_flushD", {31'd0, flushD_a}, 32'd1);
        put(0, 3'd0, 0, 0, 0);
        step(1);
        chk("beq_once", {31'd0, pc_src_a}, 32'd0);
        chk("beq_br_cnt", br_cnt_a, 32'd1);
        chk("beq_taken_cnt", taken_cnt_a, 32'd1);

        put(1, 3'd5, 32'h8000_0000, 0, 32'h100);
        step(1);
        chk("bltz_neg", {31'd0, pc_src_a}, 32'd1);
        put(0, 3'd0, 0, 0, 0);
        step(1);
        put(1, 3'd4, 32'h8000_0000, 0, 32'h104);
        step(1);
        chk("bgtz_neg", {31'd0, pc_src_a}, 32'd0);
        put(1, 3'd3, 32'h0, 0, 32'h108);
        step(1);
        chk("blez_zero", {31'd0, pc_src_a}, 32'd1);
        put(0, 3'd0, 0, 0, 0);
        step(1);
        chk("signed_br_cnt", br_cnt_a, 32'd4);
        chk("signed_taken_cnt", taken_cnt_a, 32'd3);

        put(1, 3'd2, 32'h1, 32'h2, 32'h200);
        step(1);
        chk("stall_first", {31'd0, pc_src_a}, 32'd1);
        stallM = 1'b1;
        put(0, 3'd0, 0, 0, 0);
        step(1);
        chk("stall_hold1", {31'd0, pc_src_a}, 32'd0);
        chk("stall_target", pcbranch_a, 32'h200);
        step(1);
        chk("stall_hold2", {31'd0, pc_src_a}, 32'd0);
        step(1);
        stallM = 1'b0;
        step(1);
        chk("stall_br_cnt", br_cnt_a, 32'd5);
        chk("stall_taken_cnt", taken_cnt_a, 32'd4);

        put(1, 3'd7, 0, 0, 32'h300);
        step(1);
        chk("j_pc_src", {31'd0, pc_src_a}, 32'd1);
        chk("j_target", pcbranch_a, 32'h300);
        put(1, 3'd1, 32'h9, 32'h9, 32'h400);
        step(1);
        chk("b2b_squash", {31'd0, pc_src_a}, 32'd0);
        put(0, 3'd0, 0, 0, 0);
        step(1);
        chk("b2b_br_cnt", br_cnt_a, 32'd6);
        chk("b2b_taken_cnt", taken_cnt_a, 32'd5);

        put(0, 3'd7, 0, 0, 32'h444);
        step(2);
        chk("invalid_no_redirect", {31'd0, pc_src_a}, 32'd0);
        chk("invalid_br_cnt", br_cnt_a, 32'd6);

        put(1, 3'd7, 0, 0, 32'h500);
        step(1);
        chk("mid_pc_src", {31'd0, pc_src_a}, 32'd1);
        clr = 1'b1;
        #1;
        chk("mid_clr_mask", {31'd0, pc_src_a}, 32'd0);
        put(0, 3'd0, 0, 0, 0);
        step(1);
        clr = 1'b0;
        chk("mid_br_cnt", br_cnt_a, 32'd0);
        chk("mid_taken_cnt", taken_cnt_a, 32'd0);

        for (int i = 0; i < 17; i++) begin
            put(1, 3'd7, 0, 0, 32'h1000 + 32'(i));
            step(1);
            put(0, 3'd0, 0, 0, 0);
            step(1);
        end
        chk("wrap_br_cnt_w4", {28'd0, br_cnt_b}, 32'd1);
        chk("wrap_taken_cnt_w4", {28'd0, taken_cnt_b}, 32'd1);
        chk("wrap_br_cnt_w32", br_cnt_a, 32'd17);

        step(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
